// File: rtl/mem_access_unit.sv
// Memory access stage: sequences single loads/stores against a fixed-latency RAM,
// stalls the pipeline while busy, and selects the writeback value.
module mem_access_unit #(
    parameter int ARQ              = 16,
    parameter int MEMORY_ADDR_SIZE = 13,
    parameter int RD_LATENCY       = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rd_mem_en,
    input  logic                        wr_mem_en,
    input  logic [MEMORY_ADDR_SIZE-1:0] addr,
    input  logic [ARQ-1:0]              wr_data,
    input  logic [ARQ-1:0]              alu_result,
    input  logic                        mux_mem,
    input  logic                        wb_en_in,
    input  logic [ARQ-1:0]              ram_rdata,
    output logic [MEMORY_ADDR_SIZE-1:0] ram_addr,
    output logic [ARQ-1:0]              ram_wdata,
    output logic                        ram_we,
    output logic                        ram_re,
    output logic                        stall,
    output logic [ARQ-1:0]              wb_data,
    output logic                        wb_en_out,
    output logic                        result_valid,
    output logic                        err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR      = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [2:0] LAT = 3'(RD_LATENCY);

    state_t                        state;
    state_t                        state_nxt;
    logic [2:0]                    cnt;
    logic [MEMORY_ADDR_SIZE-1:0]   addr_q;
    logic [ARQ-1:0]                wdata_q;
    logic [ARQ-1:0]                rd_data_q;
    logic                          err_q;
    logic                          req;
    logic                          accept;
    logic                          capture;

    assign req = rd_mem_en | wr_mem_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        stall        = 1'b0;
        ram_re       = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = '0;
        ram_wdata    = '0;
        result_valid = 1'b0;
        accept       = 1'b0;
        capture      = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    // Gated by rst so every control output reads 0 while reset is held.
                    stall     = rst;
                    accept    = 1'b1;
                    state_nxt = wr_mem_en ? WR : RD_WAIT;
                end
            end
            RD_WAIT: begin
                stall    = 1'b1;
                ram_addr = addr_q;
                ram_re   = (cnt == 3'd0);
                if (cnt == LAT) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end
            end
            WR: begin
                stall     = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = addr_q;
                ram_wdata = wdata_q;
                state_nxt = DONE;
            end
            DONE: begin
                result_valid = 1'b1;
                state_nxt    = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= addr;
                wdata_q <= wr_data;
                cnt     <= '0;
                // Simultaneous load+store: the store wins and the conflict is remembered.
                if (rd_mem_en && wr_mem_en) begin
                    err_q <= 1'b1;
                end
            end else if (state == RD_WAIT) begin
                cnt <= cnt + 3'd1;
            end
            if (capture) begin
                rd_data_q <= ram_rdata;
            end
        end
    end

    assign err       = err_q;
    assign wb_data   = mux_mem ? rd_data_q : alu_result;
    assign wb_en_out = wb_en_in & ~stall;

endmodule
